fetch_buffer: RTL and testbench

//  Parametrised instruction fetch buffer between the MMU/icache request path and IF.

---
 rtl/fetch_buffer.sv | 185 ++++++++++++++++++
 tb/tb_fetch_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches into a circular buffer
// and presents one instruction per handshake, reassembling word-straddling 32-bit ones.
module fetch_buffer #(
    parameter int              DEPTH    = 2,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter bit              C_EXT    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            flush_pc_i,
    output logic                       fetch_req_o,
    output logic [XLEN-1:0]            fetch_addr_o,
    input  logic                       fetch_ack_i,
    input  logic [31:0]                fetch_data_i,
    input  logic                       fetch_err_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [XLEN-1:0]            instr_pc_o,
    output logic                       instr_comp_o,
    output logic                       instr_err_o,
    output logic                       misalign_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          LW  = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {FETCH = 1'b0, DROP = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [31:0]       word_r [DEPTH];
    logic [DEPTH-1:0]  err_r, valid_r;
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [LW-1:0]     level_r, level_nxt_s;
    logic [XLEN-1:0]   fetch_addr_r, instr_pc_r, drop_pc_r;
    logic              fetch_req_r, req_nxt_s;
    logic [31:0]       lo_s, hi_s, instr_s;
    logic              half_s, comp_raw_s, need_one_s, avail_s, misalign_s;
    logic              instr_valid_s, instr_err_s;
    logic              push_s, pop_s, pop_word_s, drop_done_s;

    function automatic logic is_comp(input logic [1:0] low_bits);
        return (C_EXT == 1'b1) && (low_bits != 2'b11);
    endfunction

    // Head-of-buffer decode: which words the next instruction needs and whether they are present
    always_comb begin
        rd_nxt_s   = rd_ptr_r + PW'(1);
        half_s     = instr_pc_r[1];
        lo_s       = word_r[rd_ptr_r];
        hi_s       = word_r[rd_nxt_s];
        comp_raw_s = half_s ? is_comp(lo_s[17:16]) : is_comp(lo_s[1:0]);
        need_one_s = !half_s || comp_raw_s;
        misalign_s = (C_EXT == 1'b0) && half_s;
        avail_s    = valid_r[rd_ptr_r] && (need_one_s || valid_r[rd_nxt_s]);
        instr_valid_s = avail_s && !misalign_s;
        if (!instr_valid_s) begin
            instr_s = NOP;
        end else if (!half_s) begin
            instr_s = lo_s;
        end else if (comp_raw_s) begin
            instr_s = {16'h0000, lo_s[31:16]};
        end else begin
            instr_s = {hi_s[15:0], lo_s[31:16]};
        end
        instr_err_s = instr_valid_s && (err_r[rd_ptr_r] || (!need_one_s && err_r[rd_nxt_s]));
        pop_s       = instr_valid_s && instr_ready_i;
        // A compressed instruction in the low half leaves the word for its partner
        pop_word_s  = pop_s && (half_s || !comp_raw_s);
        push_s      = (state_r == FETCH) && fetch_req_r && fetch_ack_i;
        drop_done_s = (state_r == DROP) && fetch_ack_i;
    end

    // FSM next state: an un-acked request interrupted by a flush must be drained
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH: begin
                if (flush_i && fetch_req_r && !fetch_ack_i) begin
                    state_s = DROP;
                end else begin
                    state_s = FETCH;
                end
            end
            DROP: begin
                if (fetch_ack_i) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            default: state_s = FETCH;
        endcase
    end

    // FSM outputs: next occupancy and next fetch request
    always_comb begin
        level_nxt_s = level_r;
        if (flush_i) begin
            level_nxt_s = {LW{1'b0}};
        end else if (push_s && !pop_word_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (!push_s && pop_word_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
        if (state_s == DROP) begin
            req_nxt_s = 1'b1;
        end else begin
            req_nxt_s = (level_nxt_s < LW'(DEPTH));
        end
    end

    // FSM state register with occupancy and registered request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FETCH;
            level_r     <= {LW{1'b0}};
            fetch_req_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            level_r     <= level_nxt_s;
            fetch_req_r <= req_nxt_s;
        end
    end

    // Buffer storage, pointers, fetch address and instruction PC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_r[i] <= 32'h0000_0000;
            end
            err_r        <= {DEPTH{1'b0}};
            valid_r      <= {DEPTH{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fetch_addr_r <= RESET_PC & ~XLEN'(3);
            instr_pc_r   <= RESET_PC;
            drop_pc_r    <= RESET_PC;
        end else if (flush_i) begin
            valid_r    <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            instr_pc_r <= flush_pc_i & ~XLEN'(1);
            drop_pc_r  <= flush_pc_i & ~XLEN'(1);
            // While draining, the old address stays on the bus until its ack
            if (state_s == FETCH) begin
                fetch_addr_r <= flush_pc_i & ~XLEN'(3);
            end
        end else begin
            if (drop_done_s) begin
                fetch_addr_r <= drop_pc_r & ~XLEN'(3);
            end else if (push_s) begin
                fetch_addr_r <= fetch_addr_r + XLEN'(4);
            end
            if (push_s) begin
                word_r[wr_ptr_r]  <= fetch_data_i;
                err_r[wr_ptr_r]   <= fetch_err_i;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                instr_pc_r <= instr_pc_r + (comp_raw_s ? XLEN'(2) : XLEN'(4));
                if (pop_word_s) begin
                    valid_r[rd_ptr_r] <= 1'b0;
                    rd_ptr_r          <= rd_ptr_r + PW'(1);
                end
            end
        end
    end

    assign fetch_req_o   = fetch_req_r;
    assign fetch_addr_o  = fetch_addr_r;
    assign instr_valid_o = instr_valid_s;
    assign instr_o       = instr_s;
    assign instr_pc_o    = instr_pc_r;
    assign instr_comp_o  = instr_valid_s && is_comp(instr_s[1:0]);
    assign instr_err_o   = instr_err_s;
    assign misalign_o    = misalign_s;
    assign level_o       = level_r;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a vector table for streaming/fill behaviour
// plus hand sequences for flush, drop, fault and no-compressed corner cases.
module tb_fetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, flush, ack, err, ready, flush_n, ack_n;
    logic [31:0] flush_pc, data;

    logic        req, valid, comp, ierr, mis;
    logic [31:0] addr, instr, pc;
    logic [2:0]  level;
    logic        req_n, valid_n, comp_n, ierr_n, mis_n;
    logic [31:0] addr_n, instr_n, pc_n;
    logic [1:0]  level_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h8000_0000), .C_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .flush_pc_i(flush_pc),
        .fetch_req_o(req), .fetch_addr_o(addr), .fetch_ack_i(ack),
        .fetch_data_i(data), .fetch_err_i(err), .instr_valid_o(valid),
        .instr_ready_i(ready), .instr_o(instr), .instr_pc_o(pc),
        .instr_comp_o(comp), .instr_err_o(ierr), .misalign_o(mis), .level_o(level));

    fetch_buffer #(.DEPTH(2), .XLEN(32), .RESET_PC(32'h8000_0000), .C_EXT(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .flush_i(flush_n), .flush_pc_i(flush_pc),
        .fetch_req_o(req_n), .fetch_addr_o(addr_n), .fetch_ack_i(ack_n),
        .fetch_data_i(data), .fetch_err_i(err), .instr_valid_o(valid_n),
        .instr_ready_i(ready), .instr_o(instr_n), .instr_pc_o(pc_n),
        .instr_comp_o(comp_n), .instr_err_o(ierr_n), .misalign_o(mis_n), .level_o(level_n));

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_comp;
        logic [2:0]  e_level;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic a, logic [31:0] d, logic r, logic q, logic [31:0] ad,
                                logic v, logic [31:0] ins, logic [31:0] p, logic c, logic [2:0] l);
        vec_t t;
        t.ack = a; t.data = d; t.ready = r; t.e_req = q; t.e_addr = ad;
        t.e_valid = v; t.e_instr = ins; t.e_pc = p; t.e_comp = c; t.e_level = l;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic q, input logic [31:0] ad, input logic v,
                            input logic [31:0] ins, input logic [31:0] p, input logic c,
                            input logic e, input logic [2:0] l);
        chk({tag, ".req"},   {31'd0, req},   {31'd0, q});
        chk({tag, ".addr"},  addr,           ad);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        chk({tag, ".instr"}, instr,          ins);
        chk({tag, ".pc"},    pc,             p);
        chk({tag, ".comp"},  {31'd0, comp},  {31'd0, c});
        chk({tag, ".err"},   {31'd0, ierr},  {31'd0, e});
        chk({tag, ".level"}, {29'd0, level}, {29'd0, l});
    endtask

    task automatic chk_nc(input string tag, input logic q, input logic [31:0] ad, input logic v,
                          input logic [31:0] ins, input logic [31:0] p, input logic m,
                          input logic [1:0] l);
        chk({tag, ".req"},   {31'd0, req_n},   {31'd0, q});
        chk({tag, ".addr"},  addr_n,           ad);
        chk({tag, ".valid"}, {31'd0, valid_n}, {31'd0, v});
        chk({tag, ".instr"}, instr_n,          ins);
        chk({tag, ".pc"},    pc_n,             p);
        chk({tag, ".comp"},  {31'd0, comp_n},  32'd0);
        chk({tag, ".mis"},   {31'd0, mis_n},   {31'd0, m});
        chk({tag, ".level"}, {30'd0, level_n}, {30'd0, l});
    endtask

    task automatic drive(input logic f, input logic [31:0] fp, input logic a,
                         input logic [31:0] d, input logic e, input logic r);
        flush = f; flush_pc = fp; ack = a; data = d; err = e; ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // ack, data, ready | req, addr, valid, instr, pc, comp, level
        tbl[0]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000, 1'b0, NOP,           32'h8000_0000, 1'b0, 3'd0);
        tbl[1]  = mk(1'b1, 32'h00A0_0093, 1'b0, 1'b1, 32'h8000_0000, 1'b0, NOP,           32'h8000_0000, 1'b0, 3'd0);
        tbl[2]  = mk(1'b1, 32'h00B0_0113, 1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h00A0_0093, 32'h8000_0000, 1'b0, 3'd1);
        tbl[3]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h00A0_0093, 32'h8000_0000, 1'b0, 3'd2);
        tbl[4]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h00B0_0113, 32'h8000_0004, 1'b0, 3'd1);
        tbl[5]  = mk(1'b1, 32'h0093_4501, 1'b1, 1'b1, 32'h8000_0008, 1'b0, NOP,           32'h8000_0008, 1'b0, 3'd0);
        tbl[6]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h0093_4501, 32'h8000_0008, 1'b1, 3'd1);
        tbl[7]  = mk(1'b1, 32'h1234_00A0, 1'b1, 1'b1, 32'h8000_000C, 1'b0, NOP,           32'h8000_000A, 1'b0, 3'd1);
        tbl[8]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 3'd2);
        tbl[9]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h00A0_0093, 32'h8000_000A, 1'b0, 3'd2);
        tbl[10] = mk(1'b1, 32'h0010_0093, 1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 3'd1);
        tbl[11] = mk(1'b1, 32'h0020_0113, 1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 3'd2);
        tbl[12] = mk(1'b1, 32'h0030_0193, 1'b0, 1'b1, 32'h8000_0018, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 3'd3);
        tbl[13] = mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h8000_001C, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 3'd4);
        tbl[14] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_001C, 1'b1, 32'h0000_1234, 32'h8000_000E, 1'b1, 3'd4);
        tbl[15] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h0010_0093, 32'h8000_0010, 1'b0, 3'd3);
        tbl[16] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h0020_0113, 32'h8000_0014, 1'b0, 3'd2);
        tbl[17] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_001C, 1'b1, 32'h0030_0193, 32'h8000_0018, 1'b0, 3'd1);

        rst = 1'b1; flush_n = 1'b0; ack_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_main("rst", 1'b0, 32'h8000_0000, 1'b0, NOP, 32'h8000_0000, 1'b0, 1'b0, 3'd0);
        chk("rst.mis", {31'd0, mis}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            chk_main($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                     tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_comp, 1'b0, tbl[i].e_level);
            drive(1'b0, 32'h0, tbl[i].ack, tbl[i].data, 1'b0, tbl[i].ready);
            step();
        end

        // Flush with a request outstanding, re-targeted while draining
        drive(1'b1, 32'h8000_0102, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk_main("dropA", 1'b1, 32'h8000_001C, 1'b0, NOP, 32'h8000_0102, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 32'h8000_0106, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk_main("dropB", 1'b1, 32'h8000_001C, 1'b0, NOP, 32'h8000_0106, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 32'hBADB_AD13, 1'b0, 1'b0);
        step();
        chk_main("dropC", 1'b1, 32'h8000_0104, 1'b0, NOP, 32'h8000_0106, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h4505_0000, 1'b0, 1'b0);
        step();
        chk_main("dropD", 1'b1, 32'h8000_0108, 1'b1, 32'h0000_4505, 32'h8000_0106, 1'b1, 1'b0, 3'd1);

        // Flush coincident with ack and pop: everything discarded, no drain
        drive(1'b1, 32'h8000_0200, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
        step();
        chk_main("fap0", 1'b1, 32'h8000_0200, 1'b0, NOP, 32'h8000_0200, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b0, 1'b0);
        step();
        chk_main("fap1", 1'b1, 32'h8000_0204, 1'b1, 32'h00A0_0093, 32'h8000_0200, 1'b0, 1'b0, 3'd1);

        // Straddling instruction whose upper word carries a fault
        drive(1'b1, 32'h8000_0302, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        step();
        chk_main("str0", 1'b1, 32'h8000_0300, 1'b0, NOP, 32'h8000_0302, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h0093_0000, 1'b0, 1'b0);
        step();
        chk_main("str1", 1'b1, 32'h8000_0304, 1'b0, NOP, 32'h8000_0302, 1'b0, 1'b0, 3'd1);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_00A0, 1'b1, 1'b0);
        step();
        chk_main("str2", 1'b1, 32'h8000_0308, 1'b1, 32'h00A0_0093, 32'h8000_0302, 1'b0, 1'b1, 3'd2);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk_main("str3", 1'b1, 32'h8000_0308, 1'b1, 32'h0000_0000, 32'h8000_0306, 1'b1, 1'b1, 3'd1);

        // No-compressed instance: comp forced low, odd-halfword PC is misaligned
        drive(1'b0, 32'h0, 1'b0, 32'h0093_4501, 1'b0, 1'b0);
        ack_n = 1'b1;
        chk_nc("nc0", 1'b1, 32'h8000_0000, 1'b0, NOP, 32'h8000_0000, 1'b0, 2'd0);
        step();
        chk_nc("nc1", 1'b1, 32'h8000_0004, 1'b1, 32'h0093_4501, 32'h8000_0000, 1'b0, 2'd1);
        flush_n = 1'b1; flush_pc = 32'h8000_0402; data = 32'h0;
        step();
        chk_nc("nc2", 1'b1, 32'h8000_0400, 1'b0, NOP, 32'h8000_0402, 1'b1, 2'd0);
        flush_n = 1'b0; data = 32'h1234_5678; ready = 1'b1;
        step();
        ack_n = 1'b0;
        chk_nc("nc3", 1'b1, 32'h8000_0404, 1'b0, NOP, 32'h8000_0402, 1'b1, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
